// File: rtl/mbr_ctrl.sv
// Memory buffer register with a latency-counted RAM read FSM, prioritised
// source loads and a write buffer FIFO feeding the RAM write side.
module mbr_ctrl #(
   parameter int DATA_W   = 16,
   parameter int NUM_SRC  = 4,
   parameter int WB_DEPTH = 4,
   parameter int RAM_LAT  = 2
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [NUM_SRC-1:0]        src_load,
   input  logic [NUM_SRC*DATA_W-1:0] src_data,
   input  logic                      rd_req,
   input  logic [DATA_W-1:0]         ram_rdata,
   input  logic                      wr_push,
   input  logic                      wb_ready,
   output logic [DATA_W-1:0]         mbr_out,
   output logic [DATA_W-1:0]         wb_data,
   output logic                      wb_valid,
   output logic                      busy,
   output logic                      wb_full,
   output logic                      overflow
);

   localparam int CNT_W = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;
   localparam int PTR_W = $clog2(WB_DEPTH);
   localparam logic [CNT_W-1:0] LAT_M1   = CNT_W'(RAM_LAT - 1);
   localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(WB_DEPTH);

   typedef enum logic {IDLE, WAIT} state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [DATA_W-1:0] mbr_d;
   logic [DATA_W-1:0] load_val;
   logic              load_any;

   // Later iterations overwrite earlier ones, so the highest asserted source wins.
   always_comb begin
      load_val = '0;
      load_any = 1'b0;
      for (int unsigned i = 0; i < NUM_SRC; i++) begin
         if (src_load[i]) begin
            load_any = 1'b1;
            load_val = src_data[i*DATA_W +: DATA_W];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      mbr_d   = mbr_out;
      case (state_q)
         IDLE: begin
            if (rd_req) begin
               state_d = WAIT;
               cnt_d   = LAT_M1;
            end else if (load_any) begin
               mbr_d = load_val;
            end
         end
         WAIT: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - CNT_W'(1);
            end else begin
               mbr_d   = ram_rdata;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         mbr_out <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         mbr_out <= mbr_d;
      end
   end

   assign busy = (state_q == WAIT);

   logic [DATA_W-1:0] mem [WB_DEPTH];
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [PTR_W:0]    count;
   logic              do_push, do_pop;

   assign wb_valid = (count != '0);
   assign wb_full  = (count == FULL_CNT);
   assign do_pop   = wb_valid & wb_ready;
   // A pop in the same cycle frees the slot, so a full buffer still accepts the push.
   assign do_push  = wr_push & (~wb_full | do_pop);
   assign wb_data  = wb_valid ? mem[rd_ptr] : '0;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + (PTR_W + 1)'(1);
            2'b01:   count <= count - (PTR_W + 1)'(1);
            default: count <= count;
         endcase
         if (wr_push && wb_full && !do_pop) overflow <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n && do_push) mem[wr_ptr] <= mbr_out;
   end

endmodule

// File: doc/mbr_ctrl.md
MBR_CTRL -- requirements
Module: mbr_ctrl

Interface
REQ-001 The block SHALL be clocked by one clock; reset is synchronous and active-low.
REQ-002 Parameter DATA_W, default 16, SHALL be the MBR and memory data width in bits.
REQ-003 Parameter NUM_SRC, default 4, SHALL be the number of register load sources (minimum 1).
REQ-004 Parameter WB_DEPTH, default 4, SHALL be the write-buffer depth (power of 2, minimum 2).
REQ-005 Parameter RAM_LAT, default 2, SHALL be the RAM read latency in cycles (minimum 1).
REQ-006 clk  in  1  rising-edge clock.
REQ-007 rst_n  in  1  synchronous active-low reset.
REQ-008 src_load  in  NUM_SRC  per-source load strobes.
REQ-009 src_data  in  NUM_SRC*DATA_W  source data; source i occupies bits [i*DATA_W +: DATA_W].
REQ-010 rd_req  in  1  start a RAM read into the MBR.
REQ-011 ram_rdata  in  DATA_W  RAM read data.
REQ-012 wr_push  in  1  enqueue the current mbr_out into the write buffer.
REQ-013 wb_ready  in  1  RAM side accepts the write-buffer head.
REQ-014 mbr_out  out  DATA_W  registered MBR value.
REQ-015 wb_data  out  DATA_W  write-buffer head entry.
REQ-016 wb_valid  out  1  write buffer is not empty.
REQ-017 busy  out  1  RAM read is in flight.
REQ-018 wb_full  out  1  write buffer holds WB_DEPTH entries.
REQ-019 overflow  out  1  sticky flag: a push was dropped.

Function
REQ-020 The read FSM SHALL have two states: IDLE and WAIT; busy SHALL be 1 exactly when the FSM is in WAIT.
REQ-021 In IDLE, rd_req=1 SHALL move the FSM to WAIT and load the latency counter with RAM_LAT-1.
REQ-022 In WAIT with counter>0, the counter SHALL decrement at each edge.
REQ-023 In WAIT with counter==0, the block SHALL capture ram_rdata into mbr_out and return to IDLE at that edge, so a rd_req sampled at edge t updates mbr_out at edge t+RAM_LAT.
REQ-024 rd_req SHALL be ignored in WAIT.
REQ-025 In IDLE with rd_req=0 and any src_load bit set, mbr_out SHALL load src_data of the highest-indexed asserted source.
REQ-026 src_load SHALL be ignored in WAIT and in the IDLE cycle in which rd_req=1, because a read has priority over loads.
REQ-027 With no load and no capture, mbr_out SHALL hold its value.
REQ-028 The write buffer SHALL be a FIFO with pointer wrap modulo WB_DEPTH, an occupancy count of 0..WB_DEPTH, and no combinational path from wr_push to wb_valid.
REQ-029 On wr_push, the buffer SHALL enqueue the pre-edge mbr_out value; wr_push SHALL be legal in either FSM state.
REQ-030 When wb_valid=1 and wb_ready=1, the buffer SHALL pop the head at the edge; wb_data SHALL show the new head from the next cycle.
REQ-031 A push and a pop in the same cycle SHALL both take effect, including when the buffer is full; occupancy SHALL be unchanged.
REQ-032 A push when the buffer is full and no pop occurs SHALL be dropped, leave the buffer unchanged, and set overflow.
REQ-033 overflow SHALL remain 1 until reset.
REQ-034 wb_ready while the buffer is empty SHALL have no effect.
REQ-035 wb_data SHALL be 0 while the buffer is empty.

Reset
REQ-036 When rst_n=0 at an edge, the block SHALL set mbr_out=0, FSM=IDLE, counter=0, occupancy=0, both pointers=0, overflow=0, busy=0, wb_valid=0, wb_full=0.
REQ-037 Reset SHALL take priority over every other input, including mid-read; a read aborted by reset SHALL NOT later update mbr_out.

Verification
REQ-038 Load priority: src_load=4'b1010, src1=16'h1111, src3=16'h3333 -> mbr_out=16'h3333 next cycle; src_load=4'b0001, src0=16'h00AA -> mbr_out=16'h00AA.
REQ-039 Read latency (RAM_LAT=2): rd_req at edge t with ram_rdata=16'hBEEF held -> busy=1 for 2 cycles, mbr_out=16'hBEEF after edge t+2; a src_load=4'b1000 asserted during WAIT -> ignored.
REQ-040 Read-vs-load collision: rd_req=1 and src_load=4'b0100 in the same IDLE cycle -> mbr_out unchanged until ram_rdata is captured.
REQ-041 Buffer fill/overflow: push 16'h0001..16'h0004 with wb_ready=0 -> wb_full=1; fifth push -> dropped, overflow=1; drain with wb_ready=1 -> wb_data order 1,2,3,4, then wb_valid=0 and overflow still 1.
REQ-042 Full push+pop: buffer full and wr_push=1 with wb_ready=1 -> occupancy stays 4, overflow stays 0, new entry appears at tail.
REQ-043 Mid-read reset: rd_req, then rst_n=0 one cycle later -> busy=0 and mbr_out=0; mbr_out stays 0 after the original capture cycle.
